// File: rtl/pcie_cfg_req_ctrl.sv
// Configuration/message request sequencer: captures one request, launches the TLP,
// waits for encoder completion and (for config requests) the RC completion or a timeout.
module pcie_cfg_req_ctrl #(
    parameter logic [15:0] CPL_TIMEOUT = 16'd1000
) (
    input  logic        user_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [1:0]  req_func_num,
    input  logic [9:0]  req_reg_num,
    input  logic [3:0]  req_be,
    input  logic [2:0]  req_msg_routing,
    input  logic [7:0]  req_msg_code,
    input  logic [31:0] req_data,
    output logic [1:0]  pkt_type,
    output logic [1:0]  pkt_func_num,
    output logic [9:0]  pkt_reg_num,
    output logic [3:0]  pkt_1dw_be,
    output logic [2:0]  pkt_msg_routing,
    output logic [7:0]  pkt_msg_code,
    output logic [31:0] pkt_data,
    output logic        pkt_start,
    input  logic        pkt_done,
    input  logic        cpl_valid,
    input  logic [2:0]  cpl_status,
    input  logic [31:0] cpl_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, WAIT_CPL, RESP} state_t;

    localparam logic [1:0]  TYPE_CFGRD = 2'b00;
    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_CPL_ERR = 2'b01;
    localparam logic [1:0]  ST_TIMEOUT = 2'b10;
    localparam logic [15:0] CNT_LAST   = CPL_TIMEOUT - 16'd1;

    state_t      state;
    logic [15:0] cpl_cnt;

    // busy is a registered mirror of state != IDLE; gating with reset keeps ready low in reset
    assign req_ready = ~busy & ~reset;

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cpl_cnt         <= '0;
            busy            <= 1'b0;
            pkt_start       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_status      <= '0;
            rsp_data        <= '0;
            pkt_type        <= '0;
            pkt_func_num    <= '0;
            pkt_reg_num     <= '0;
            pkt_1dw_be      <= '0;
            pkt_msg_routing <= '0;
            pkt_msg_code    <= '0;
            pkt_data        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pkt_type        <= req_type;
                        pkt_func_num    <= req_func_num;
                        pkt_reg_num     <= req_reg_num;
                        pkt_1dw_be      <= req_be;
                        pkt_msg_routing <= req_msg_routing;
                        pkt_msg_code    <= req_msg_code;
                        pkt_data        <= req_data;
                        pkt_start       <= 1'b1;
                        busy            <= 1'b1;
                        state           <= START;
                    end
                end
                START: begin
                    pkt_start <= 1'b0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // messages are posted: no completion follows, respond immediately
                    if (pkt_done) begin
                        if (pkt_type[1]) begin
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_OK;
                            rsp_data   <= '0;
                            state      <= RESP;
                        end else begin
                            cpl_cnt <= '0;
                            state   <= WAIT_CPL;
                        end
                    end
                end
                WAIT_CPL: begin
                    cpl_cnt <= cpl_cnt + 16'd1;
                    if (cpl_valid) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= (cpl_status == 3'd0) ? ST_OK : ST_CPL_ERR;
                        rsp_data   <= (pkt_type == TYPE_CFGRD && cpl_status == 3'd0) ? cpl_data : 32'd0;
                        state      <= RESP;
                    end else if (cpl_cnt == CNT_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_TIMEOUT;
                        rsp_data   <= '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    pkt_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_cfg_req_ctrl.sv
// Directed bench: one instance with the default timeout, one with CPL_TIMEOUT=8.
module tb_pcie_cfg_req_ctrl;

    logic        user_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_type = '0;
    logic [1:0]  req_func_num = '0;
    logic [9:0]  req_reg_num = '0;
    logic [3:0]  req_be = '0;
    logic [2:0]  req_msg_routing = '0;
    logic [7:0]  req_msg_code = '0;
    logic [31:0] req_data = '0;
    logic        pkt_done = 1'b0;
    logic        cpl_valid = 1'b0;
    logic [2:0]  cpl_status = '0;
    logic [31:0] cpl_data = '0;

    logic        req_ready, pkt_start, rsp_valid, busy;
    logic [1:0]  pkt_type, pkt_func_num, rsp_status;
    logic [9:0]  pkt_reg_num;
    logic [3:0]  pkt_1dw_be;
    logic [2:0]  pkt_msg_routing;
    logic [7:0]  pkt_msg_code;
    logic [31:0] pkt_data, rsp_data;

    logic        t_req_ready, t_pkt_start, t_rsp_valid, t_busy;
    logic [1:0]  t_pkt_type, t_pkt_func_num, t_rsp_status;
    logic [9:0]  t_pkt_reg_num;
    logic [3:0]  t_pkt_1dw_be;
    logic [2:0]  t_pkt_msg_routing;
    logic [7:0]  t_pkt_msg_code;
    logic [31:0] t_pkt_data, t_rsp_data;

    pcie_cfg_req_ctrl dut (
        .user_clk(user_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_func_num(req_func_num), .req_reg_num(req_reg_num),
        .req_be(req_be), .req_msg_routing(req_msg_routing), .req_msg_code(req_msg_code),
        .req_data(req_data), .pkt_type(pkt_type), .pkt_func_num(pkt_func_num),
        .pkt_reg_num(pkt_reg_num), .pkt_1dw_be(pkt_1dw_be), .pkt_msg_routing(pkt_msg_routing),
        .pkt_msg_code(pkt_msg_code), .pkt_data(pkt_data), .pkt_start(pkt_start),
        .pkt_done(pkt_done), .cpl_valid(cpl_valid), .cpl_status(cpl_status),
        .cpl_data(cpl_data), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .busy(busy)
    );

    pcie_cfg_req_ctrl #(.CPL_TIMEOUT(16'd8)) dut8 (
        .user_clk(user_clk), .reset(reset), .req_valid(req_valid), .req_ready(t_req_ready),
        .req_type(req_type), .req_func_num(req_func_num), .req_reg_num(req_reg_num),
        .req_be(req_be), .req_msg_routing(req_msg_routing), .req_msg_code(req_msg_code),
        .req_data(req_data), .pkt_type(t_pkt_type), .pkt_func_num(t_pkt_func_num),
        .pkt_reg_num(t_pkt_reg_num), .pkt_1dw_be(t_pkt_1dw_be), .pkt_msg_routing(t_pkt_msg_routing),
        .pkt_msg_code(t_pkt_msg_code), .pkt_data(t_pkt_data), .pkt_start(t_pkt_start),
        .pkt_done(pkt_done), .cpl_valid(cpl_valid), .cpl_status(cpl_status),
        .cpl_data(cpl_data), .rsp_valid(t_rsp_valid), .rsp_status(t_rsp_status),
        .rsp_data(t_rsp_data), .busy(t_busy)
    );

    always #5 user_clk = ~user_clk;

    int n_chk = 0, n_fail = 0;
    int rsp_cnt = 0, t_rsp_cnt = 0, ps_cnt = 0, dbl = 0, stab_err = 0, acc_cnt = 0, bad_acc = 0;
    bit stab_en = 1'b1, prev_ps = 1'b0;
    logic [1:0]  exp_type;
    logic [9:0]  exp_reg;
    logic [3:0]  exp_be;
    logic [7:0]  exp_code;
    logic [31:0] exp_data;

    // Mid-cycle monitor: pulse counts and pkt_* stability against the bench's record of the request
    always @(negedge user_clk) begin
        if (!reset) begin
            if (rsp_valid) rsp_cnt++;
            if (t_rsp_valid) t_rsp_cnt++;
            if (pkt_start) ps_cnt++;
            if (pkt_start && prev_ps) dbl++;
            prev_ps = pkt_start;
            if (stab_en && busy && !pkt_start &&
                (pkt_type !== exp_type || pkt_reg_num !== exp_reg || pkt_1dw_be !== exp_be ||
                 pkt_msg_code !== exp_code || pkt_data !== exp_data))
                stab_err++;
        end
    end

    always @(posedge user_clk) begin
        if (!reset && req_valid && req_ready) begin
            acc_cnt++;
            if (busy) bad_acc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] t, input logic [9:0] r, input logic [3:0] be,
                           input logic [7:0] code, input logic [31:0] d);
        req_type = t; req_func_num = 2'd1; req_reg_num = r; req_be = be;
        req_msg_routing = 3'd4; req_msg_code = code; req_data = d;
    endtask

    // Waits for the launch pulse, records what was captured, checks it lasts one cycle
    task automatic wait_start(output int n);
        n = 0;
        while (!pkt_start && n < 20) begin tick(); n++; end
        chk("pkt_start_seen", pkt_start, 1'b1);
        exp_type = req_type; exp_reg = req_reg_num; exp_be = req_be;
        exp_code = req_msg_code; exp_data = req_data;
        chk("pkt_reg_num", pkt_reg_num, exp_reg);
        chk("pkt_data", pkt_data, exp_data);
        tick();
        chk("pkt_start_one_cycle", pkt_start, 1'b0);
    endtask

    task automatic issue(input logic [1:0] t, input logic [9:0] r, input logic [3:0] be,
                         input logic [7:0] code, input logic [31:0] d);
        int n;
        set_req(t, r, be, code, d);
        req_valid = 1'b1;
        wait_start(n);
        req_valid = 1'b0;
    endtask

    // Entered one cycle after pkt_start; pkt_done rises gap cycles after pkt_start
    task automatic pulse_done(input int gap);
        repeat (gap - 1) tick();
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    task automatic send_cpl(input int wait_cyc, input logic [2:0] st, input logic [31:0] d);
        repeat (wait_cyc) tick();
        cpl_valid = 1'b1; cpl_status = st; cpl_data = d;
        tick();
        cpl_valid = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] st, input logic [31:0] d);
        int r0;
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, "_rsp_status"}, rsp_status, st);
        chk({tag, "_rsp_data"}, rsp_data, d);
        r0 = rsp_cnt;
        tick();
        chk({tag, "_rsp_valid_drop"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_single"}, rsp_cnt - r0, 1);
        chk({tag, "_rsp_data_hold"}, rsp_data, d);
    endtask

    initial begin
        int n, r0, p0, a0;
        exp_type = '0; exp_reg = '0; exp_be = '0; exp_code = '0; exp_data = '0;
        #2;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pkt_start", pkt_start, 1'b0);
        chk("rst_rsp", {rsp_valid, rsp_status, rsp_data}, '0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1'b1);

        // CfgRd success
        p0 = ps_cnt;
        issue(2'b00, 10'h004, 4'hF, 8'h00, 32'h0);
        pulse_done(3);
        chk("rd_busy", busy, 1'b1);
        send_cpl(10, 3'd0, 32'h1234_5678);
        chk_rsp("rd", 2'b00, 32'h1234_5678);
        chk("rd_one_start", ps_cnt - p0, 1);

        // Reset while waiting for the completion
        issue(2'b00, 10'h3FF, 4'h3, 8'h00, 32'h0BAD_0001);
        pulse_done(2);
        repeat (2) tick();
        r0 = rsp_cnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {req_ready, busy, pkt_start, rsp_valid, rsp_status}, '0);
        chk("mid_rst_pkt", {pkt_reg_num, pkt_1dw_be, pkt_func_num}, '0);
        chk("mid_rst_pkt_data", pkt_data, 32'h0);
        chk("mid_rst_rsp_data", rsp_data, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_release_ready", req_ready, 1'b1);
        send_cpl(1, 3'd0, 32'hFFFF_0000);
        tick();
        chk("late_cpl_ignored", rsp_cnt - r0, 0);
        issue(2'b00, 10'h008, 4'hF, 8'h00, 32'h0);
        pulse_done(2);
        send_cpl(3, 3'd0, 32'hA5A5_0001);
        chk_rsp("rd_after_rst", 2'b00, 32'hA5A5_0001);

        // CfgWr with completion error status
        issue(2'b01, 10'h010, 4'hF, 8'h00, 32'hDEAD_BEEF);
        pulse_done(2);
        send_cpl(3, 3'd1, 32'hCAFE_F00D);
        chk_rsp("wr_cpl_err", 2'b01, 32'h0);

        // CfgRd with a non-zero completion status: error, data suppressed
        issue(2'b00, 10'h020, 4'h1, 8'h00, 32'h0);
        pulse_done(1);
        send_cpl(0, 3'd4, 32'h1111_2222);
        chk_rsp("rd_cpl_err", 2'b01, 32'h0);

        // Msg: response right after pkt_done, stray completion ignored
        issue(2'b10, 10'h000, 4'h0, 8'h7E, 32'h0);
        pulse_done(2);
        chk_rsp("msg", 2'b00, 32'h0);
        r0 = rsp_cnt;
        send_cpl(0, 3'd0, 32'h9999_9999);
        send_cpl(0, 3'd0, 32'h9999_9999);
        tick();
        chk("stray_cpl_no_rsp", rsp_cnt - r0, 0);
        chk("stray_cpl_idle", busy, 1'b0);

        // Three back-to-back MsgD with req_valid held throughout
        a0 = acc_cnt;
        set_req(2'b11, 10'h000, 4'h0, 8'h50, 32'h0000_0050);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_start(n);
            if (i > 0) chk("b2b_accept_after_resp", n, 1);
            if (i == 2) req_valid = 1'b0;
            else set_req(2'b11, 10'h000, 4'h0, 8'h51 + 8'(i), 32'h0000_0051 + 32'(i));
            chk("b2b_no_accept_busy", req_ready, 1'b0);
            pulse_done(2);
            chk("b2b_rsp_valid", rsp_valid, 1'b1);
            tick();
            chk("b2b_ready_after_resp", req_ready, 1'b1);
        end
        tick();
        chk("b2b_accepts", acc_cnt - a0, 3);

        chk("pkt_stable", stab_err, 0);
        chk("no_double_start", dbl, 0);
        chk("accept_only_idle", bad_acc, 0);

        // Timeout instance; the default-timeout instance gets left behind and is ignored
        stab_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int run = 0; run < 2; run++) begin
            set_req(2'b00, 10'h0C0, 4'hF, 8'h00, 32'h0);
            req_valid = 1'b1;
            n = 0;
            while (!t_pkt_start && n < 20) begin tick(); n++; end
            chk("to_start", t_pkt_start, 1'b1);
            req_valid = 1'b0;
            tick();
            pulse_done(1);
            r0 = t_rsp_cnt;
            if (run == 0) begin
                n = 0;
                while (!t_rsp_valid && n < 30) begin tick(); n++; end
                chk("to_wait_cycles", n, 8);
                chk("to_status", t_rsp_status, 2'b10);
                chk("to_data", t_rsp_data, 32'h0);
            end else begin
                send_cpl(7, 3'd0, 32'h0000_0055);
                chk("to_edge_rsp_valid", t_rsp_valid, 1'b1);
                chk("to_edge_status", t_rsp_status, 2'b00);
                chk("to_edge_data", t_rsp_data, 32'h0000_0055);
            end
            tick();
            chk("to_single_rsp", t_rsp_cnt - r0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
